// File: rtl/rpm_pkg.sv
// Shared types and defaults for the tachometer pulse generator.
// Configuration storage is sized for the widest supported build; WIDTH must not exceed RPM_WIDTH.
package rpm_pkg;

    localparam int RPM_WIDTH      = 32;
    localparam int RPM_MIN_PERIOD = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } rpm_state_e;

    typedef struct packed {
        logic [RPM_WIDTH-1:0] period;
        logic [RPM_WIDTH-1:0] high;
    } rpm_cfg_t;

endpackage

// File: rtl/rpm_cfg_check.sv
// Combinational legality check for an offered period/high-time pair.
// Legal when period >= MIN_PERIOD and 1 <= high < period.
module rpm_cfg_check
    import rpm_pkg::*;
#(
    parameter int WIDTH      = RPM_WIDTH,
    parameter int MIN_PERIOD = RPM_MIN_PERIOD
) (
    input  logic [WIDTH-1:0] cfg_period_i,
    input  logic [WIDTH-1:0] cfg_high_i,
    output logic             legal_o
);

    assign legal_o = (cfg_period_i >= WIDTH'(MIN_PERIOD)) &&
                     (cfg_high_i != {WIDTH{1'b0}}) &&
                     (cfg_high_i < cfg_period_i);

endmodule

// File: rtl/rpm_pulse_gen.sv
// Programmable tachometer pulse generator: periodic waveform with configurable period and
// high time, reconfigured over valid/ready only on period boundaries.
module rpm_pulse_gen
    import rpm_pkg::*;
#(
    parameter int WIDTH      = RPM_WIDTH,
    parameter int MIN_PERIOD = RPM_MIN_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_high,
    output logic             cfg_ready,
    output logic             cfg_error,
    output logic             rpm_signal,
    output logic             period_start,
    output logic [WIDTH-1:0] pulse_count,
    output logic             busy
);

    rpm_state_e       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] act_period_q, act_period_d;
    logic [WIDTH-1:0] act_high_q, act_high_d;
    logic             has_cfg_q, has_cfg_d;
    logic             pending_q, pending_d;
    rpm_cfg_t         shadow_q, shadow_d;

    logic             cfg_ready_q, cfg_error_q, rpm_signal_q, period_start_q, busy_q;
    logic [WIDTH-1:0] pulse_count_q;

    logic             cfg_legal;
    logic             accept;
    logic             at_boundary;
    logic             start;

    rpm_cfg_check #(
        .WIDTH      (WIDTH),
        .MIN_PERIOD (MIN_PERIOD)
    ) u_cfg_check (
        .cfg_period_i (cfg_period),
        .cfg_high_i   (cfg_high),
        .legal_o      (cfg_legal)
    );

    assign accept      = cfg_valid && cfg_ready_q;
    assign at_boundary = (state_q == RUN) && (cnt_q == (act_period_q - WIDTH'(1)));

    // Config storage, period counter and state transitions.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        act_period_d = act_period_q;
        act_high_d   = act_high_q;
        has_cfg_d    = has_cfg_q;
        pending_d    = pending_q;
        shadow_d     = shadow_q;
        start        = 1'b0;

        // Idle or boundary acceptances take effect directly; mid-period ones wait in the shadow.
        if (accept && cfg_legal) begin
            if ((state_q == IDLE) || at_boundary) begin
                act_period_d = cfg_period;
                act_high_d   = cfg_high;
                has_cfg_d    = 1'b1;
            end else begin
                shadow_d.period = RPM_WIDTH'(cfg_period);
                shadow_d.high   = RPM_WIDTH'(cfg_high);
                pending_d       = 1'b1;
            end
        end else begin
            pending_d = pending_q;
        end

        case (state_q)
            IDLE: begin
                if (enable && has_cfg_q) begin
                    state_d = RUN;
                    cnt_d   = {WIDTH{1'b0}};
                    start   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (at_boundary) begin
                    if (pending_q) begin
                        act_period_d = WIDTH'(shadow_q.period);
                        act_high_d   = WIDTH'(shadow_q.high);
                        pending_d    = 1'b0;
                    end else begin
                        pending_d = pending_d;
                    end
                    cnt_d = {WIDTH{1'b0}};
                    if (enable) begin
                        start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {WIDTH{1'b0}};
            end
        endcase
    end

    // State, configuration and registered outputs; outputs reflect the post-edge state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= {WIDTH{1'b0}};
            act_period_q   <= {WIDTH{1'b0}};
            act_high_q     <= {WIDTH{1'b0}};
            has_cfg_q      <= 1'b0;
            pending_q      <= 1'b0;
            shadow_q       <= '0;
            cfg_ready_q    <= 1'b0;
            cfg_error_q    <= 1'b0;
            rpm_signal_q   <= 1'b0;
            period_start_q <= 1'b0;
            pulse_count_q  <= {WIDTH{1'b0}};
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            act_period_q   <= act_period_d;
            act_high_q     <= act_high_d;
            has_cfg_q      <= has_cfg_d;
            pending_q      <= pending_d;
            shadow_q       <= shadow_d;
            cfg_ready_q    <= !pending_d;
            cfg_error_q    <= accept && !cfg_legal;
            rpm_signal_q   <= (state_d == RUN) && (cnt_d < act_high_d);
            period_start_q <= start;
            busy_q         <= (state_d != IDLE);
            if (start) begin
                pulse_count_q <= pulse_count_q + WIDTH'(1);
            end else begin
                pulse_count_q <= pulse_count_q;
            end
        end
    end

    assign cfg_ready    = cfg_ready_q;
    assign cfg_error    = cfg_error_q;
    assign rpm_signal   = rpm_signal_q;
    assign period_start = period_start_q;
    assign pulse_count  = pulse_count_q;
    assign busy         = busy_q;

endmodule
